// File: rtl/tile_scheduler.sv
// Walks a triangle's 32x32 tile bounding box row-major and emits GPU core slave writes.
// Latency: 8 constant writes, then 6 writes + 1 advance cycle per tile, then 1 fence write.
// Backpressure: each write holds address/data until m_wait_request is low; desc_ready only in IDLE.
module tile_scheduler (
  input  logic               clk,
  input  logic               reset,
  input  logic               desc_valid,
  output logic               desc_ready,
  input  logic [15:0]        desc_color,
  input  logic signed [18:0] desc_A01,
  input  logic signed [18:0] desc_A12,
  input  logic signed [18:0] desc_A20,
  input  logic signed [23:0] desc_B01,
  input  logic signed [23:0] desc_B12,
  input  logic signed [23:0] desc_B20,
  input  logic signed [31:0] desc_w0,
  input  logic signed [31:0] desc_w1,
  input  logic signed [31:0] desc_w2,
  input  logic [7:0]         desc_tx0,
  input  logic [7:0]         desc_ty0,
  input  logic [7:0]         desc_tx1,
  input  logic [7:0]         desc_ty1,
  input  logic [31:0]        desc_fb_base,
  input  logic [15:0]        desc_stride,
  output logic [3:0]         m_address,
  output logic               m_write,
  output logic [31:0]        m_write_data,
  input  logic               m_wait_request,
  output logic               busy,
  output logic [15:0]        tiles_issued
);

  typedef enum logic [2:0] {S_IDLE, S_CONST, S_TILE, S_ADV, S_FENCE} state_t;

  state_t      state, state_nxt;
  logic [2:0]  idx, idx_nxt;

  // Descriptor constants, A/B already sign-extended to 32 bits
  logic [15:0] color;
  logic [15:0] stride;
  logic [31:0] a01, a12, a20, b01, b12, b20;
  logic [7:0]  tx, ty, tx0, tx1, ty1;

  // Incremental per-tile state
  logic [31:0] w0, w1, w2;
  logic [31:0] wrow0, wrow1, wrow2;
  logic [31:0] row_addr, tile_addr;
  logic [31:0] nrow0, nrow1, nrow2, nrow_addr;

  logic accept, degenerate, wr_acc;

  assign desc_ready = (state == S_IDLE) && !reset;
  assign busy       = (state != S_IDLE);
  assign accept     = desc_valid && desc_ready;
  assign degenerate = (desc_tx1 < desc_tx0) || (desc_ty1 < desc_ty0);
  assign wr_acc     = m_write && !m_wait_request;

  assign nrow0     = wrow0 + (b01 << 5);
  assign nrow1     = wrow1 + (b12 << 5);
  assign nrow2     = wrow2 + (b20 << 5);
  assign nrow_addr = row_addr + ({16'd0, stride} << 5);

  // State and write-index register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
      idx   <= 3'd0;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
    end
  end

  // Next state and the write currently presented to the slave
  always_comb begin
    state_nxt    = state;
    idx_nxt      = idx;
    m_write      = 1'b0;
    m_address    = 4'd0;
    m_write_data = 32'd0;
    case (state)
      S_IDLE: begin
        if (accept && !degenerate) begin
          state_nxt = S_CONST;
          idx_nxt   = 3'd0;
        end
      end
      S_CONST: begin
        m_write = 1'b1;
        case (idx)
          3'd0:    begin m_address = 4'd1;  m_write_data = {16'd0, color}; end
          3'd1:    begin m_address = 4'd2;  m_write_data = a01; end
          3'd2:    begin m_address = 4'd3;  m_write_data = a12; end
          3'd3:    begin m_address = 4'd4;  m_write_data = a20; end
          3'd4:    begin m_address = 4'd10; m_write_data = b01; end
          3'd5:    begin m_address = 4'd11; m_write_data = b12; end
          3'd6:    begin m_address = 4'd12; m_write_data = b20; end
          default: begin m_address = 4'd9;  m_write_data = {16'd0, stride}; end
        endcase
        if (wr_acc) begin
          if (idx == 3'd7) begin
            state_nxt = S_TILE;
            idx_nxt   = 3'd0;
          end else begin
            idx_nxt = idx + 3'd1;
          end
        end
      end
      S_TILE: begin
        m_write = 1'b1;
        case (idx)
          3'd0:    begin m_address = 4'd5; m_write_data = w0; end
          3'd1:    begin m_address = 4'd6; m_write_data = w1; end
          3'd2:    begin m_address = 4'd7; m_write_data = w2; end
          3'd3:    begin m_address = 4'd0; m_write_data = 32'd0; end
          3'd4:    begin m_address = 4'd8; m_write_data = tile_addr; end
          default: begin m_address = 4'd0; m_write_data = 32'd2; end
        endcase
        if (wr_acc) begin
          if (idx == 3'd5) begin
            state_nxt = S_ADV;
            idx_nxt   = 3'd0;
          end else begin
            idx_nxt = idx + 3'd1;
          end
        end
      end
      S_ADV: begin
        if ((tx < tx1) || (ty < ty1)) state_nxt = S_TILE;
        else                          state_nxt = S_FENCE;
        idx_nxt = 3'd0;
      end
      S_FENCE: begin
        m_write      = 1'b1;
        m_address    = 4'd0;
        m_write_data = 32'd4;
        if (wr_acc) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Descriptor capture and per-tile incremental stepping (adds and shifts only)
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      color <= '0; stride <= '0;
      a01 <= '0; a12 <= '0; a20 <= '0;
      b01 <= '0; b12 <= '0; b20 <= '0;
      tx <= '0; ty <= '0; tx0 <= '0; tx1 <= '0; ty1 <= '0;
      w0 <= '0; w1 <= '0; w2 <= '0;
      wrow0 <= '0; wrow1 <= '0; wrow2 <= '0;
      row_addr <= '0; tile_addr <= '0;
    end else if (accept) begin
      color  <= desc_color;
      stride <= desc_stride;
      a01 <= {{13{desc_A01[18]}}, desc_A01};
      a12 <= {{13{desc_A12[18]}}, desc_A12};
      a20 <= {{13{desc_A20[18]}}, desc_A20};
      b01 <= {{8{desc_B01[23]}}, desc_B01};
      b12 <= {{8{desc_B12[23]}}, desc_B12};
      b20 <= {{8{desc_B20[23]}}, desc_B20};
      tx  <= desc_tx0; ty <= desc_ty0;
      tx0 <= desc_tx0; tx1 <= desc_tx1; ty1 <= desc_ty1;
      w0 <= desc_w0; w1 <= desc_w1; w2 <= desc_w2;
      wrow0 <= desc_w0; wrow1 <= desc_w1; wrow2 <= desc_w2;
      row_addr  <= desc_fb_base;
      tile_addr <= desc_fb_base;
    end else if (state == S_ADV) begin
      if (tx < tx1) begin
        tx        <= tx + 8'd1;
        w0        <= w0 + (a01 << 5);
        w1        <= w1 + (a12 << 5);
        w2        <= w2 + (a20 << 5);
        tile_addr <= tile_addr + 32'd64;
      end else if (ty < ty1) begin
        ty        <= ty + 8'd1;
        tx        <= tx0;
        wrow0     <= nrow0;
        wrow1     <= nrow1;
        wrow2     <= nrow2;
        w0        <= nrow0;
        w1        <= nrow1;
        w2        <= nrow2;
        row_addr  <= nrow_addr;
        tile_addr <= nrow_addr;
      end
    end
  end

  // Count tiles whose start-write-to-RAM command was accepted
  always_ff @(posedge clk or posedge reset) begin
    if (reset) tiles_issued <= 16'd0;
    else if (state == S_TILE && idx == 3'd5 && wr_acc) tiles_issued <= tiles_issued + 16'd1;
  end

endmodule

// File: doc/tile_scheduler.md
# tile_scheduler

Walks one triangle's tile bounding box in row-major order and emits the register and command writes that drive the GPU core's command slave for every 32x32 tile. It accepts one triangle descriptor at a time through a valid/ready handshake. It computes per-tile edge-function start values and framebuffer addresses incrementally, with no multipliers. It sits between the CPU/DMA-side triangle setup logic and the GPU core control slave, on the system clock domain.

## Interface
- No parameters. Tile size is fixed at 32x32 pixels, 16 bpp.
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- desc_valid  in  1  descriptor present
- desc_ready  out  1  descriptor can be accepted
- desc_color  in  16  fill colour
- desc_A01, desc_A12, desc_A20  in  19 each, signed  per-pixel x step of each edge function
- desc_B01, desc_B12, desc_B20  in  24 each, signed  per-pixel y step of each edge function
- desc_w0, desc_w1, desc_w2  in  32 each, signed  edge values at the top-left pixel of tile (tx0,ty0)
- desc_tx0, desc_ty0, desc_tx1, desc_ty1  in  8 each  inclusive tile bounding box
- desc_fb_base  in  32  byte address of tile (tx0,ty0) top-left pixel
- desc_stride  in  16  framebuffer row pitch in bytes
- m_address  out  4  GPU core slave register index
- m_write  out  1  write strobe
- m_write_data  out  32  write data
- m_wait_request  in  1  slave stall
- busy  out  1  descriptor in progress
- tiles_issued  out  16  count of tiles whose start-write command was accepted

## Operation
- Handshake:
  - desc_ready = 1 only in IDLE.
  - All desc_* fields are captured on the clk edge where desc_valid & desc_ready.
- Degenerate box: if tx1<tx0 or ty1<ty0, the descriptor is accepted and the block returns to IDLE next cycle with no writes.
- States: IDLE -> CONST -> TILE -> ADV -> (TILE | FENCE) -> IDLE.
- CONST issues 8 writes, in order as (address, data):
  - (1, color)
  - (2, sext A01), (3, sext A12), (4, sext A20)
  - (10, sext B01), (11, sext B12), (12, sext B20)
  - (9, stride)
- TILE issues 6 writes, in order:
  - (5, w0), (6, w1), (7, w2)
  - (0, 0): start raster
  - (8, tile_addr)
  - (0, 2): start write to RAM
- ADV advances one tile, with m_write=0:
  - If tx<tx1: tx++, w_i += A_i<<5, tile_addr += 64.
  - Otherwise, if ty<ty1: ty++, tx=tx0, wrow_i += B_i<<5, w_i = new wrow_i, row_addr += stride<<5, tile_addr = new row_addr. Then go to TILE.
  - Otherwise go to FENCE.
- FENCE issues one write (0, 4): wait for the RAM writer to drain. Then go to IDLE.
- Arithmetic:
  - A and B are sign-extended to 32 bits before shifting.
  - All w, wrow, row_addr and tile_addr sums are 32-bit modulo 2^32; overflow wraps silently.
- tiles_issued:
  - Increments when the (0,2) write is accepted.
  - Wraps at 65535->0.
  - Cleared only by reset.

## Timing
- Write rule:
  - A write is accepted on an edge where m_write=1 and m_wait_request=0.
  - m_address and m_write_data stay stable while stalled.
  - The next write is presented the following cycle, with no bubble inside CONST or TILE.
- Latency without stalls: acceptance at cycle 0; CONST writes cycles 1-8; first TILE writes 9-14; ADV 15.
  - Single tile: FENCE 16, IDLE 17 with desc_ready=1.
  - Each additional tile adds 7 cycles.
  - Each stalled cycle adds exactly 1 cycle.
- busy = 1 from the cycle after acceptance through the FENCE cycle, inclusive. busy = 0 for a degenerate box.
- Reset values:
  - desc_ready=0 while reset is asserted, 1 in the first cycle after release.
  - m_write=0, m_address=0, m_write_data=0.
  - busy=0, tiles_issued=0.
- Reset mid-descriptor: returns immediately to IDLE with m_write=0 and the descriptor discarded. No fence is issued.
- desc_valid held high in any state other than IDLE has no effect.

## Test plan
- One tile (0,0)-(0,0), color 0xF800, w=(100,200,300), fb_base 0x1000, wait_request=0:
  - Exactly 15 writes in the listed order, the last being (0,4).
  - (8,0x1000) is issued.
  - tiles_issued=1; desc_ready returns at cycle 17.
- Box (1,2)-(3,3), A01=-5, B01=7, w0=1000, fb_base 0x2000, stride 1280:
  - 6 tiles in row-major order.
  - w0 sequence 1000, 840, 680, 1224, 1064, 904.
  - tile_addr sequence 0x2000, 0x2040, 0x2080, 0xC000, 0xC040, 0xC080.
- wait_request held high 3 cycles on the 4th CONST write and 2 cycles on the (0,2) write:
  - Outputs stay stable while stalled; no write is duplicated or lost.
  - Total duration is 5 cycles longer than the unstalled run.
- Degenerate box tx0=5, tx1=4: no m_write, busy stays 0, desc_ready high 1 cycle after acceptance.
- Reset asserted during the 3rd tile of a 6-tile descriptor:
  - m_write low in the same cycle; tiles_issued=0.
  - A new descriptor after release restarts with CONST.
- w0=0x7FFFFFF0, A01=+1, box (0,0)-(1,0): the second tile's w0 is 0x80000010 (wraps).
